fir_cmplx_ctrl: RTL



---
 rtl/fir_cmplx_pkg.sv | 19 +
 rtl/fir_cmplx_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/fir_cmplx_pkg.sv
// Shared types and constants for the complex FIR sequencing controller.
package fir_cmplx_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_WRITE   = 2'd3
  } fsm_state_e;

  localparam int CHANNEL_COEFF_TAPS = 20;
  localparam int DEF_MAC_LAT        = 2;

  // A single-tap filter still needs a 1-bit index port.
  function automatic int TAP_IDX_W(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_cmplx_ctrl.sv
// Sequencer for the complex FIR: lockstep I/Q pops, one shared MAC stepped over
// all taps, pipeline drain, then a paired write to the real/imag output FIFOs.
module fir_cmplx_ctrl
  import fir_cmplx_pkg::*;
#(
  parameter int TAPS       = CHANNEL_COEFF_TAPS,
  parameter int DECIMATION = 1,
  parameter int MAC_LAT    = DEF_MAC_LAT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_empty,
  input  logic                       q_empty,
  output logic                       i_rd_en,
  output logic                       q_rd_en,
  output logic                       shift_en,
  output logic [TAP_IDX_W(TAPS)-1:0] tap_idx,
  output logic                       mac_en,
  output logic                       mac_clr,
  input  logic                       y_real_full,
  input  logic                       y_imag_full,
  output logic                       y_real_wr_en,
  output logic                       y_imag_wr_en,
  output logic                       busy,
  output logic [31:0]                out_count
);

  localparam int TW = TAP_IDX_W(TAPS);
  localparam int DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  fsm_state_e    state_q;
  logic [TW-1:0] tap_q;
  logic [DW-1:0] dec_q;
  logic [LW-1:0] drn_q;
  logic [31:0]   cnt_q;

  logic pop_ok, wr_ok, pop, wr, in_cmp;

  assign pop_ok = !i_empty && !q_empty;
  assign wr_ok  = !y_real_full && !y_imag_full;

  // Every output is qualified by reset so nothing toggles while reset is low,
  // even before the first clock edge has cleared the state.
  assign pop    = reset && (state_q == ST_LOAD) && pop_ok;
  assign in_cmp = reset && (state_q == ST_COMPUTE);
  assign wr     = reset && (state_q == ST_WRITE) && wr_ok;

  assign i_rd_en      = pop;
  assign q_rd_en      = pop;
  assign shift_en     = pop;
  assign mac_en       = in_cmp;
  assign mac_clr      = in_cmp && (tap_q == '0);
  assign tap_idx      = in_cmp ? tap_q : '0;
  assign y_real_wr_en = wr;
  assign y_imag_wr_en = wr;
  assign busy         = reset && (state_q != ST_LOAD);
  assign out_count    = reset ? cnt_q : 32'd0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      tap_q   <= '0;
      dec_q   <= '0;
      drn_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (pop_ok) begin
            if (dec_q == DW'(DECIMATION - 1)) begin
              dec_q   <= '0;
              state_q <= ST_COMPUTE;
            end else begin
              dec_q <= dec_q + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (tap_q == TW'(TAPS - 1)) begin
            tap_q   <= '0;
            state_q <= (MAC_LAT == 0) ? ST_WRITE : ST_DRAIN;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drn_q == LW'(MAC_LAT - 1)) begin
            drn_q   <= '0;
            state_q <= ST_WRITE;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        ST_WRITE: begin
          // Both FIFOs must have room; a half-written complex result is never allowed.
          if (wr_ok) begin
            cnt_q   <= cnt_q + 32'd1;
            state_q <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule
